tick_sched: RTL
===============

# tick_sched

Command-driven scheduler for the system clock divider. It holds the divide ratio and counter and sequences them through idle, free-running and one-shot operation. It emits a one-cycle tick enable and a 50% duty toggled clock. It sits between control logic (buttons, CPU register write, FSMs) and the 1 Hz-style timebase consumers, so the timebase can be stopped, restarted, re-rated or fired once at runtime.

## Interface
- CNT_W, 25: counter and divide-ratio width.
- DEF_DIV, 25000000: divide ratio loaded at reset; tick period = div+1 cycles.
- iClk  in  1  system clock; all logic on rising edge.
- iRst  in  1  reset, synchronous, active-high.
- iCmdValid  in  1  command present.
- iCmdOp  in  2  00 STOP, 01 RUN, 10 ONESHOT, 11 LOAD.
- iCmdDiv  in  CNT_W  new divide ratio; used by LOAD only.
- oCmdReady  out  1  command can be accepted; registered.
- oTick  out  1  one-cycle pulse at each terminal count.
- oClk  out  1  toggles on every tick.
- oDone  out  1  one-cycle pulse when a ONESHOT completes.
- oBusy  out  1  high when state is not IDLE.
- oState  out  2  IDLE=00, RUN=01, SHOT=10.

## Operation
- Accept = iCmdValid & oCmdReady, sampled at the rising edge. The effect is visible in the next cycle. iCmdOp and iCmdDiv must be stable while iCmdValid is high.
- Registers:
  - state, reset IDLE.
  - cnt[CNT_W], reset 0.
  - div_q[CNT_W], reset DEF_DIV.
  - oTick, oClk, oDone, reset 0.
  - oCmdReady, reset 1.
- Counting happens only in RUN or SHOT:
  - if cnt != div_q: cnt <= cnt+1.
  - else (terminal count): cnt <= 0, oTick <= 1, oClk <= ~oClk.
- In IDLE, cnt holds 0.
- oTick and oDone default to 0 every cycle.
- State transitions:
  - IDLE: RUN -> RUN; ONESHOT -> SHOT; LOAD -> IDLE with div_q <= iCmdDiv; STOP -> IDLE.
  - RUN: STOP -> IDLE; RUN -> RUN with phase restart; ONESHOT -> SHOT; LOAD -> RUN with div_q <= iCmdDiv.
  - SHOT: oCmdReady = 0, so no command is accepted. At terminal count: oTick <= 1, oDone <= 1, oClk toggles, state <= IDLE, oCmdReady <= 1.
- Every accepted command sets cnt <= 0.
- STOP also sets oClk <= 0.
- RUN, ONESHOT and LOAD leave oClk unchanged.
- oCmdReady is registered: 0 exactly while state is SHOT.
- oBusy and oState are decoded from state.
- div_q = 0 is legal: a tick on every cycle, and oClk toggles every cycle.
- Arithmetic is unsigned. cnt never exceeds div_q; a compare/reset prevents wrap.
- If LOAD sets div_q below the current cnt, the cnt <= 0 on accept prevents overshoot.

## Timing
- Let E0 be the accept edge of RUN or ONESHOT:
  - after edge Ek, cnt = k for k <= div_q.
  - at edge E(div_q+1), cnt returns to 0.
  - oTick is high for the one cycle after E(div_q+1).
- Latency from accept to the first oTick is div_q+1 edges. The RUN tick period is exactly div_q+1 cycles.
- oClk period is 2*(div_q+1) cycles at 50% duty.
- oDone coincides with the final oTick of a SHOT. In that same cycle, oState = IDLE and oCmdReady = 1.
- A new command can be accepted in the cycle oDone is high.
- Command at a terminal-count edge in RUN: the command wins. There is no oTick or oClk toggle at that edge, and cnt <= 0.
- Reset is synchronous: when iRst is high at an edge, all registers take reset values regardless of iCmdValid. This includes mid-SHOT; no oDone is produced.
- Commands presented while iRst is high are ignored.

## Test plan
- Reset defaults, DEF_DIV=4 → after reset:
  - oState=00, oCmdReady=1, oTick=oClk=oDone=0.
  - no ticks for 20 cycles.
- Free-run, DEF_DIV=4, RUN accepted at E0:
  - oTick high after E5, E10, E15.
  - oClk toggles at each of those edges: period 10, duty 50%.
- LOAD while running: RUN, then at E2 LOAD iCmdDiv=1:
  - oState stays 01, cnt restarts.
  - oTick after E4, E6, E8.
  - a subsequent LOAD of 0 gives oTick every cycle.
- ONESHOT, div_q=3:
  - oCmdReady=0 during SHOT; iCmdValid held high with STOP is not accepted.
  - after E4: oTick=oDone=1, oState=00, oCmdReady=1.
  - no further ticks.
- Collisions:
  - STOP at a RUN terminal-count edge: no oTick, oClk=0, oState=00.
  - RUN re-issued at a terminal count: the tick is suppressed and the next tick comes div_q+1 edges later.
- Reset mid-SHOT (div_q=10, iRst at E5):
  - state IDLE, cnt=0, div_q=DEF_DIV.
  - no oDone at E11.

Source files
------------

// File: rtl/tick_sched_if.sv
// Command and status bundle between a controller and the tick scheduler.
// The controller drives the command fields and the scheduler returns the timebase outputs.
interface tick_sched_if #(
    parameter int CNT_W = 25
);
    logic             iCmdValid;
    logic [1:0]       iCmdOp;
    logic [CNT_W-1:0] iCmdDiv;
    logic             oCmdReady;
    logic             oTick;
    logic             oClk;
    logic             oDone;
    logic             oBusy;
    logic [1:0]       oState;

    modport master (
        output iCmdValid, iCmdOp, iCmdDiv,
        input  oCmdReady, oTick, oClk, oDone, oBusy, oState
    );

    modport slave (
        input  iCmdValid, iCmdOp, iCmdDiv,
        output oCmdReady, oTick, oClk, oDone, oBusy, oState
    );
endinterface

// File: rtl/tick_sched.sv
// Command-driven clock divider: stop, free-run, one-shot and runtime re-rating.
// Emits a one-cycle tick at each terminal count plus a 50% duty toggled clock.
module tick_sched #(
    parameter int CNT_W   = 25,
    parameter int DEF_DIV = 25000000
) (
    input  logic         iClk,
    input  logic         iRst,
    tick_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SHOT = 2'b10
    } state_t;

    localparam logic [1:0] OP_STOP    = 2'b00;
    localparam logic [1:0] OP_RUN     = 2'b01;
    localparam logic [1:0] OP_ONESHOT = 2'b10;
    localparam logic [1:0] OP_LOAD    = 2'b11;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic             accept_s;
    logic             terminal_s;

    assign accept_s   = bus.iCmdValid & ready_q;
    assign terminal_s = (cnt_q == div_q);

    // Next-state, counter and output-pulse logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        clk_d   = clk_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (accept_s) begin
                    // An accepted command always restarts the phase, even at terminal count.
                    cnt_d = CNT_W'(0);
                    case (bus.iCmdOp)
                        OP_STOP: begin
                            state_d = ST_IDLE;
                            clk_d   = 1'b0;
                        end
                        OP_RUN:     state_d = ST_RUN;
                        OP_ONESHOT: state_d = ST_SHOT;
                        OP_LOAD:    div_d   = bus.iCmdDiv;
                        default:    state_d = state_q;
                    endcase
                end else if (state_q == ST_IDLE) begin
                    cnt_d = CNT_W'(0);
                end else if (terminal_s) begin
                    cnt_d  = CNT_W'(0);
                    tick_d = 1'b1;
                    clk_d  = ~clk_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SHOT: begin
                if (terminal_s) begin
                    cnt_d   = CNT_W'(0);
                    tick_d  = 1'b1;
                    done_d  = 1'b1;
                    clk_d   = ~clk_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_W'(0);
            end
        endcase

        ready_d = (state_d != ST_SHOT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_W'(0);
            div_q   <= CNT_W'(DEF_DIV);
            tick_q  <= 1'b0;
            clk_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            clk_q   <= clk_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign bus.oCmdReady = ready_q;
    assign bus.oTick     = tick_q;
    assign bus.oClk      = clk_q;
    assign bus.oDone     = done_q;
    assign bus.oBusy     = (state_q != ST_IDLE);
    assign bus.oState    = state_q;
endmodule
